// File: rtl/axi_stream_remove_header.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_remove_header
// Strips a per-packet N-byte header from an AXI-Stream packet, returns it on a
// header channel and re-aligns the payload to the MSB lane.
// Optional : define AXIS_REMOVE_HDR_ERR_EN to add the hdr_err short-header pulse.
// Revision : 1.0 - initial release
// ============================================================================
module axi_stream_remove_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_remove,
    input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
    output logic                    ready_remove,
    output logic                    valid_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
    output logic [DATA_BYTE_WD-1:0] keep_hdr,
    input  logic                    ready_hdr,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
`ifdef AXIS_REMOVE_HDR_ERR_EN
    ,
    output logic                    hdr_err
`endif
);

    localparam int c_NW = $clog2(DATA_BYTE_WD + 1);
    localparam logic [c_NW-1:0] c_N_MAX = c_NW'(DATA_BYTE_WD);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FIRST = 2'd1;
    localparam logic [1:0] c_BODY  = 2'd2;
    localparam logic [1:0] c_FLUSH = 2'd3;

    logic [1:0]              r_state;
    logic [c_NW-1:0]         r_n;
    logic [DATA_WD-1:0]      r_res_data;
    logic [DATA_BYTE_WD-1:0] r_res_keep;

    logic                    w_out_free;
    logic                    w_acc;
    logic [c_NW-1:0]         w_n_cmd;
    logic [c_NW-1:0]         w_inv_n;
    logic [DATA_BYTE_WD-1:0] w_top_mask;
    logic [DATA_WD-1:0]      w_shl_data;
    logic [DATA_BYTE_WD-1:0] w_shl_keep;
    logic [DATA_WD-1:0]      w_shr_data;
    logic [DATA_BYTE_WD-1:0] w_shr_keep;
    logic                    w_load;
    logic [DATA_WD-1:0]      w_ld_data;
    logic [DATA_BYTE_WD-1:0] w_ld_keep;
    logic                    w_ld_last;

    // Expand a per-lane keep into a per-bit data mask.
    function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[i*8 +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    assign w_out_free   = !valid_out || ready_out;
    assign w_acc        = valid_in && ready_in;
    assign ready_remove = (r_state == c_IDLE);

    // Lanes [top N] carry header bytes; the rest shifts up as residual.
    assign w_top_mask = ~({DATA_BYTE_WD{1'b1}} >> r_n);
    assign w_shl_data = data_in << {r_n, 3'b000};
    assign w_shl_keep = keep_in << r_n;
    assign w_inv_n    = c_N_MAX - r_n;
    assign w_shr_data = data_in >> {w_inv_n, 3'b000};
    assign w_shr_keep = keep_in >> w_inv_n;

    always_comb begin
        if (int'(byte_remove_cnt) > DATA_BYTE_WD) begin
            w_n_cmd = c_N_MAX;
        end else begin
            w_n_cmd = c_NW'(byte_remove_cnt);
        end
    end

    always_comb begin
        ready_in = 1'b0;
        case (r_state)
            c_FIRST: ready_in = !valid_hdr && w_out_free;
            c_BODY:  ready_in = w_out_free;
            default: ready_in = 1'b0;
        endcase
    end

    always_comb begin
        w_load    = 1'b0;
        w_ld_data = w_shl_data;
        w_ld_keep = w_shl_keep;
        w_ld_last = 1'b1;
        case (r_state)
            c_FIRST: w_load = w_acc && last_in;
            c_BODY: begin
                w_load    = w_acc;
                w_ld_data = r_res_data | w_shr_data;
                w_ld_keep = r_res_keep | w_shr_keep;
                w_ld_last = last_in && (w_shl_keep == '0);
            end
            c_FLUSH: begin
                w_load    = w_out_free;
                w_ld_data = r_res_data;
                w_ld_keep = r_res_keep;
            end
            default: w_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_n        <= '0;
            r_res_data <= '0;
            r_res_keep <= '0;
            valid_hdr  <= 1'b0;
            data_hdr   <= '0;
            keep_hdr   <= '0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            keep_out   <= '0;
            last_out   <= 1'b0;
`ifdef AXIS_REMOVE_HDR_ERR_EN
            hdr_err    <= 1'b0;
`endif
        end else begin
            if (valid_hdr && ready_hdr) begin
                valid_hdr <= 1'b0;
            end
            if (valid_out && ready_out) begin
                valid_out <= 1'b0;
            end
            if (w_load) begin
                valid_out <= 1'b1;
                data_out  <= w_ld_data & lane_mask(w_ld_keep);
                keep_out  <= w_ld_keep;
                last_out  <= w_ld_last;
            end
`ifdef AXIS_REMOVE_HDR_ERR_EN
            hdr_err <= 1'b0;
`endif
            case (r_state)
                c_IDLE: begin
                    if (valid_remove) begin
                        r_n     <= w_n_cmd;
                        r_state <= c_FIRST;
                    end
                end
                c_FIRST: begin
                    if (w_acc) begin
                        if (r_n != '0) begin
                            valid_hdr <= 1'b1;
                            data_hdr  <= data_in & lane_mask(w_top_mask);
                            keep_hdr  <= w_top_mask & keep_in;
                        end
`ifdef AXIS_REMOVE_HDR_ERR_EN
                        hdr_err <= ((keep_in & w_top_mask) != w_top_mask);
`endif
                        r_res_data <= w_shl_data;
                        r_res_keep <= w_shl_keep;
                        r_state    <= last_in ? c_IDLE : c_BODY;
                    end
                end
                c_BODY: begin
                    if (w_acc) begin
                        r_res_data <= w_shl_data;
                        r_res_keep <= w_shl_keep;
                        if (last_in) begin
                            r_state <= (w_shl_keep == '0) ? c_IDLE : c_FLUSH;
                        end
                    end
                end
                default: begin
                    if (w_out_free) begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_remove_header.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_stream_remove_header
// Directed and randomized bench with a byte-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_stream_remove_header;

    localparam int DW = 32;
    localparam int DB = 4;
    localparam int CW = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [DB-1:0] k;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic [DB-1:0] keep_in;
    logic          last_in;
    logic          ready_in;
    logic          valid_remove;
    logic [CW-1:0] byte_remove_cnt;
    logic          ready_remove;
    logic          valid_hdr;
    logic [DW-1:0] data_hdr;
    logic [DB-1:0] keep_hdr;
    logic          ready_hdr;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [DB-1:0] keep_out;
    logic          last_out;
    logic          ready_out;
`ifdef AXIS_REMOVE_HDR_ERR_EN
    logic          hdr_err;
`endif

    always #5 clk = ~clk;

    axi_stream_remove_header #(
        .DATA_WD(DW), .DATA_BYTE_WD(DB), .BYTE_CNT_WD(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in),
        .last_in(last_in), .ready_in(ready_in),
        .valid_remove(valid_remove), .byte_remove_cnt(byte_remove_cnt),
        .ready_remove(ready_remove),
        .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr),
        .ready_hdr(ready_hdr),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out),
        .last_out(last_out), .ready_out(ready_out)
`ifdef AXIS_REMOVE_HDR_ERR_EN
        , .hdr_err(hdr_err)
`endif
    );

    int    src_cmd[$];
    beat_t src_beat[$];
    beat_t exp_hdr[$];
    beat_t exp_out[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_err = 0;
    int    seen_err = 0;
    int    rmode = 0;
    int    cyc_local = 0;
    bit    gaps = 0;
    bit    ignore_out = 0;
    bit    cmd_acc = 0;
    bit    beat_acc = 0;
    bit    out_hold = 0;
    bit    hdr_hold = 0;
    beat_t out_saved;
    beat_t hdr_saved;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DB-1:0] top_mask(input int k);
        logic [DB-1:0] f;
        f = '1;
        return ~(f >> k);
    endfunction

    function automatic beat_t mk(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l);
        beat_t b;
        b.d = d;
        b.k = k;
        b.l = l;
        return b;
    endfunction

    // Reference: flatten the kept bytes, peel off N, repack MSB-first.
    task automatic model_packet(input int cnt, input beat_t beats[$]);
        logic [7:0] bytes[$];
        logic [7:0] pay[$];
        beat_t      b;
        int         n;
        n = (cnt > DB) ? DB : cnt;
        src_cmd.push_back(cnt);
        foreach (beats[i]) begin
            src_beat.push_back(beats[i]);
            for (int j = 0; j < DB; j++) begin
                if (beats[i].k[DB-1-j]) bytes.push_back(beats[i].d[DW-1-8*j -: 8]);
            end
        end
        if (n > 0) begin
            b = '0;
            for (int j = 0; j < n; j++) b.d[DW-1-8*j -: 8] = beats[0].d[DW-1-8*j -: 8];
            b.k = top_mask(n) & beats[0].k;
            exp_hdr.push_back(b);
            if ((beats[0].k & top_mask(n)) != top_mask(n)) exp_err++;
        end
        for (int i = n; i < bytes.size(); i++) pay.push_back(bytes[i]);
        if (pay.size() == 0) begin
            exp_out.push_back(mk('0, '0, 1'b1));
        end
        for (int i = 0; i < pay.size(); i += DB) begin
            b = '0;
            for (int j = 0; j < DB; j++) begin
                if (i + j < pay.size()) begin
                    b.d[DW-1-8*j -: 8] = pay[i+j];
                    b.k[DB-1-j] = 1'b1;
                end
            end
            b.l = (i + DB >= pay.size());
            exp_out.push_back(b);
        end
    endtask

    task automatic gen_random_packet();
        beat_t beats[$];
        beat_t b;
        int    nb;
        int    lk;
        nb = $urandom_range(1, 4);
        lk = $urandom_range(1, DB);
        for (int i = 0; i < nb; i++) begin
            b.k = (i == nb - 1) ? top_mask(lk) : '1;
            b.l = (i == nb - 1);
            b.d = $urandom;
            for (int j = 0; j < DB; j++) if (!b.k[j]) b.d[8*j +: 8] = 8'h00;
            beats.push_back(b);
        end
        model_packet($urandom_range(0, 7), beats);
    endtask

    task automatic cycle();
        beat_t h;
        @(negedge clk);
        cyc_local++;
        if (cmd_acc) begin valid_remove = 1'b0; cmd_acc = 1'b0; end
        if (beat_acc) begin valid_in = 1'b0; beat_acc = 1'b0; end
        case (rmode)
            0: begin ready_hdr = 1'b1; ready_out = 1'b1; end
            1: begin
                ready_hdr = ($urandom_range(0, 3) != 0);
                ready_out = ($urandom_range(0, 3) != 0);
            end
            default: begin
                ready_hdr = (cyc_local > 5);
                ready_out = !(cyc_local inside {[4:6]});
            end
        endcase
        if (!valid_remove && src_cmd.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
            valid_remove    = 1'b1;
            byte_remove_cnt = CW'(src_cmd[0]);
        end
        if (!valid_in && src_beat.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
            valid_in = 1'b1;
            data_in  = src_beat[0].d;
            keep_in  = src_beat[0].k;
            last_in  = src_beat[0].l;
        end
        #1;
        if (out_hold) check("out_hold", {valid_out, data_out, keep_out, last_out}, {1'b1, out_saved});
        if (hdr_hold) check("hdr_hold", {valid_hdr, data_hdr, keep_hdr}, {1'b1, hdr_saved.d, hdr_saved.k});
        out_hold  = valid_out && !ready_out;
        out_saved = mk(data_out, keep_out, last_out);
        hdr_hold  = valid_hdr && !ready_hdr;
        hdr_saved = mk(data_hdr, keep_hdr, 1'b0);
        if (valid_out && !ready_out) check("ready_in_stall", ready_in, 0);
        if (valid_remove && ready_remove) begin cmd_acc = 1'b1; void'(src_cmd.pop_front()); end
        if (valid_in && ready_in) begin beat_acc = 1'b1; void'(src_beat.pop_front()); end
        if (valid_hdr && ready_hdr && !ignore_out) begin
            if (exp_hdr.size() == 0) check("hdr_extra", {data_hdr, keep_hdr}, 0);
            else begin
                h = exp_hdr.pop_front();
                check("hdr_beat", {data_hdr, keep_hdr}, {h.d, h.k});
            end
        end
        if (valid_out && ready_out && !ignore_out) begin
            if (exp_out.size() == 0) check("out_extra", {data_out, keep_out, last_out}, 0);
            else begin
                h = exp_out.pop_front();
                check("out_beat", {data_out, keep_out, last_out}, h);
            end
        end
`ifdef AXIS_REMOVE_HDR_ERR_EN
        if (hdr_err && !ignore_out) seen_err++;
`endif
    endtask

    task automatic run(input int mode, input bit g, input int budget);
        rmode     = mode;
        gaps      = g;
        cyc_local = 0;
        while ((src_cmd.size() + src_beat.size() + exp_hdr.size() + exp_out.size()) > 0
               && cyc_local < budget) cycle();
        check("drain", src_cmd.size() + src_beat.size() + exp_hdr.size() + exp_out.size(), 0);
        repeat (3) cycle();
    endtask

    task automatic push_case1();
        beat_t b[$];
        b = '{mk(32'hAABBCCDD, 4'hF, 0), mk(32'h11223344, 4'hF, 0), mk(32'h55667788, 4'hC, 1)};
        src_cmd.push_back(2);
        foreach (b[i]) src_beat.push_back(b[i]);
        exp_hdr.push_back(mk(32'hAABB0000, 4'hC, 0));
        exp_out.push_back(mk(32'hCCDD1122, 4'hF, 0));
        exp_out.push_back(mk(32'h33445566, 4'hF, 1));
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_remove = 1'b0; byte_remove_cnt = '0; ready_hdr = 1'b1; ready_out = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid_hdr", valid_hdr, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_ready_remove", ready_remove, 1);
        check("rst_ready_in", ready_in, 0);
        check("rst_out_regs", {data_out, keep_out, last_out, data_hdr, keep_hdr}, 0);
        rst_n = 1'b1;

        push_case1();
        run(0, 0, 200);

        src_cmd.push_back(1);
        src_beat.push_back(mk(32'hAABBCCDD, 4'hF, 0));
        src_beat.push_back(mk(32'h11223344, 4'hE, 1));
        exp_hdr.push_back(mk(32'hAA000000, 4'h8, 0));
        exp_out.push_back(mk(32'hBBCCDD11, 4'hF, 0));
        exp_out.push_back(mk(32'h22330000, 4'hC, 1));
        src_cmd.push_back(4);
        src_beat.push_back(mk(32'hAABBCCDD, 4'hF, 0));
        src_beat.push_back(mk(32'h11223344, 4'h8, 1));
        exp_hdr.push_back(mk(32'hAABBCCDD, 4'hF, 0));
        exp_out.push_back(mk(32'h11000000, 4'h8, 1));
        src_cmd.push_back(2);
        src_beat.push_back(mk(32'hAABB0000, 4'hC, 1));
        exp_hdr.push_back(mk(32'hAABB0000, 4'hC, 0));
        exp_out.push_back(mk(32'h00000000, 4'h0, 1));
        src_cmd.push_back(2);
        src_beat.push_back(mk(32'hAABB0000, 4'h8, 1));
        exp_hdr.push_back(mk(32'hAABB0000, 4'h8, 0));
        exp_out.push_back(mk(32'h00000000, 4'h0, 1));
        exp_err++;
        run(0, 0, 200);

        push_case1();
        run(2, 0, 200);

        // Partial packet left in BODY, then reset mid-stream.
        ignore_out = 1'b1;
        src_cmd.push_back(2);
        src_beat.push_back(mk(32'h01020304, 4'hF, 0));
        src_beat.push_back(mk(32'h05060708, 4'hF, 0));
        rmode = 0; gaps = 0; cyc_local = 0;
        while (src_beat.size() > 0 && cyc_local < 50) cycle();
        check("partial_consumed", src_beat.size(), 0);
        @(negedge clk);
        rst_n = 1'b0; valid_in = 1'b0; valid_remove = 1'b0; cmd_acc = 1'b0; beat_acc = 1'b0;
        @(negedge clk);
        check("mid_rst_valid_hdr", valid_hdr, 0);
        check("mid_rst_valid_out", valid_out, 0);
        check("mid_rst_ready_remove", ready_remove, 1);
        check("mid_rst_ready_in", ready_in, 0);
        rst_n = 1'b1;
        src_cmd.delete(); src_beat.delete(); exp_hdr.delete(); exp_out.delete();
        out_hold = 1'b0; hdr_hold = 1'b0; ignore_out = 1'b0;
        push_case1();
        run(0, 0, 200);

        for (int batch = 0; batch < 15; batch++) begin
            for (int p = 0; p < 10; p++) gen_random_packet();
            run(1, 1, 3000);
        end
        check("idle_ready_remove", ready_remove, 1);
`ifdef AXIS_REMOVE_HDR_ERR_EN
        check("hdr_err_pulses", seen_err, exp_err);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
